uart_rx_byte: RTL



---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_sync_edge.sv | 23 ++
 rtl/uart_rx_byte.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and receiver state encoding for the host UART
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int SAMPLE_MID = 7;
    localparam int DATA_BITS  = 8;
    localparam int BAUD       = 9600;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

endpackage

// File: rtl/uart_sync_edge.sv
// uart_sync_edge: two-flop synchroniser for an asynchronous level with a one-cycle rising-edge pulse
module uart_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic level_o,
    output logic rise_o
);

    logic [2:0] sync_q;

    // two metastability flops followed by a history flop for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= {3{RST_VAL}};
        else     sync_q <= {sync_q[1:0], async_i};
    end

    assign level_o = sync_q[1];
    assign rise_o  = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver on the 16x oversample tick with a one-entry valid/ready buffer
// Optional even parity bit and parity_err output when UART_PARITY_EN is defined.
module uart_rx_byte
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_clk_16,
    input  logic       rx,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
`ifdef UART_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    logic       tick;
    logic       rx_s;
    logic       clk16_level_unused;
    logic       rx_rise_unused;
    rx_state_t  state_q;
    logic [3:0] cnt_q;
    logic [2:0] bitn_q;
    logic [7:0] shift_q;
    logic [7:0] data_q;
    logic       valid_q;
    logic       frame_err_q;
    logic       overrun_q;
    logic       last;
    logic       stop_samp;
    logic       deliver;
    logic       xfer;
`ifdef UART_PARITY_EN
    logic       par_q;
    logic       parity_err_q;
    logic       bad_par;
`endif

    uart_sync_edge #(.RST_VAL(1'b0)) u_clk16 (
        .clk    (clk),
        .rst    (rst),
        .async_i(uart_clk_16),
        .level_o(clk16_level_unused),
        .rise_o (tick)
    );

    uart_sync_edge #(.RST_VAL(1'b1)) u_rx (
        .clk    (clk),
        .rst    (rst),
        .async_i(rx),
        .level_o(rx_s),
        .rise_o (rx_rise_unused)
    );

    // stop-sample detection and buffer handshake qualifiers
    always_comb begin
        last      = cnt_q == 4'(OVERSAMPLE - 1);
        stop_samp = tick && state_q == STOP && last;
        xfer      = valid_q && rx_ready;
`ifdef UART_PARITY_EN
        bad_par   = ^{shift_q, par_q};
        deliver   = stop_samp && rx_s && !bad_par;
`else
        deliver   = stop_samp && rx_s;
`endif
    end

    // frame FSM: all progress is gated by the oversample tick; error pulses last one clk
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bitn_q       <= '0;
            shift_q      <= '0;
            frame_err_q  <= 1'b0;
`ifdef UART_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            frame_err_q  <= 1'b0;
`ifdef UART_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            if (tick) begin
                case (state_q)
                    IDLE: begin
                        if (!rx_s) begin
                            state_q <= START;
                            cnt_q   <= '0;
                        end
                    end
                    START: begin
                        if (cnt_q == 4'(SAMPLE_MID)) begin
                            state_q <= rx_s ? IDLE : DATA;
                            cnt_q   <= '0;
                            bitn_q  <= '0;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                    DATA: begin
                        if (last) begin
                            shift_q[bitn_q] <= rx_s;
                            cnt_q           <= '0;
                            bitn_q          <= bitn_q + 3'd1;
`ifdef UART_PARITY_EN
                            if (bitn_q == 3'(DATA_BITS - 1)) state_q <= PARITY;
`else
                            if (bitn_q == 3'(DATA_BITS - 1)) state_q <= STOP;
`endif
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
`ifdef UART_PARITY_EN
                    PARITY: begin
                        if (last) begin
                            par_q   <= rx_s;
                            cnt_q   <= '0;
                            state_q <= STOP;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
`endif
                    STOP: begin
                        if (last) begin
                            state_q      <= IDLE;
                            cnt_q        <= '0;
                            frame_err_q  <= !rx_s;
`ifdef UART_PARITY_EN
                            parity_err_q <= rx_s && bad_par;
`endif
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // one-entry output buffer: a held byte is never overwritten unless consumed in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (deliver && (!valid_q || xfer)) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
            end else if (deliver) begin
                overrun_q <= 1'b1;
            end else if (xfer) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = state_q != IDLE;
`ifdef UART_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule
